jk_seq_driver: RTL and testbench

//  Drives a jk_ff so that its q follows a target bit stream (LSB first).

---
 rtl/jk_seq_driver_pkg.sv | 19 +
 rtl/jk_seq_driver_excite.sv | 15 +
 rtl/jk_seq_driver.sv | 114 +++++++++++
 tb/tb_jk_seq_driver.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_seq_driver_pkg.sv
// Shared constants and types for jk_seq_driver and the reusable jk_excite block.
// FSM encodings and JK mode encodings ({j,k}) live here.
package jk_seq_driver_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_TOG  = 2'b11;

  typedef struct packed {
    logic j;
    logic k;
  } jk_t;

endpackage

// File: rtl/jk_seq_driver_excite.sv
// jk_excite: combinational JK excitation, (target next state t, current q) -> (j, k).
// Written as plain boolean terms so an X on q propagates to j/k.
module jk_excite
  import jk_seq_driver_pkg::*;
(
  input  logic t_i,
  input  logic q_i,
  input  logic toggle_mode_i,
  output jk_t  jk_o
);

  assign jk_o.j = toggle_mode_i ? (t_i ^ q_i) : (t_i & ~q_i);
  assign jk_o.k = toggle_mode_i ? (t_i ^ q_i) : (~t_i & q_i);

endmodule

// File: rtl/jk_seq_driver.sv
// jk_seq_driver: steps a jk_ff through a target word LSB first, optionally checking q one cycle later.
// Check logic is built only when JK_DRV_CHECK_EN is defined; FSM and j/k timing are identical either way.
module jk_seq_driver
  import jk_seq_driver_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter bit TOGGLE_MODE = 1'b0,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             q_fb,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  jk_t              ex, jk_out;

  jk_excite u_excite (
    .t_i           (shreg_q[0]),
    .q_i           (q_fb),
    .toggle_mode_i (TOGGLE_MODE),
    .jk_o          (ex)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d   = ST_DRIVE;
          shreg_d   = in_data;
          bit_cnt_d = '0;
        end
      end
      ST_DRIVE: begin
        shreg_d   = shreg_q >> 1;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // j/k are held at zero everywhere but DRIVE, including while reset is asserted.
  always_comb begin
    in_ready = (state_q == ST_IDLE);
    busy     = (state_q == ST_DRIVE) || (state_q == ST_DONE);
    done     = (state_q == ST_DONE);
    jk_out   = (state_q == ST_DRIVE) ? ex : jk_t'(JK_HOLD);
  end

  assign j = jk_out.j;
  assign k = jk_out.k;

`ifdef JK_DRV_CHECK_EN
  logic             exp_q, exp_d;
  logic             chk_pend_q, chk_pend_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  // The bit driven in a DRIVE cycle must appear on q_fb the following cycle.
  always_comb begin
    exp_d      = (state_q == ST_DRIVE) ? shreg_q[0] : exp_q;
    chk_pend_d = (state_q == ST_DRIVE);
    err_cnt_d  = (mismatch && (err_cnt_q != {ERR_W{1'b1}})) ? err_cnt_q + ERR_W'(1) : err_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q      <= 1'b0;
      chk_pend_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      exp_q      <= exp_d;
      chk_pend_q <= chk_pend_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign mismatch = chk_pend_q & (q_fb ^ exp_q);
  assign err_cnt  = err_cnt_q;
`else
  assign mismatch = 1'b0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_jk_seq_driver.sv
// Bench for jk_seq_driver: three instances (set/reset mode, toggle mode, 2-bit error counter),
// each closing the loop through a behavioural jk_ff, with a queue of expected q bits.
`timescale 1ns/1ps
module tb_jk_seq_driver;

  logic       clk = 1'b0;
  logic       reset, in_valid, force_low;
  logic [7:0] in_data;
  logic [2:0] q, q_fb, j, k, in_ready, busy, done, mismatch;
  logic [7:0] err0, err1;
  logic [1:0] err2;
  int         n_checks = 0;
  int         n_fail = 0;
  bit         exp_q[$];

  always #5 clk = ~clk;

  assign q_fb = force_low ? 3'b000 : q;

  jk_seq_driver #(.WIDTH(8), .TOGGLE_MODE(1'b0), .ERR_W(8)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data),
    .q_fb(q_fb[0]), .j(j[0]), .k(k[0]), .busy(busy[0]), .done(done[0]),
    .mismatch(mismatch[0]), .err_cnt(err0));

  jk_seq_driver #(.WIDTH(8), .TOGGLE_MODE(1'b1), .ERR_W(8)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data),
    .q_fb(q_fb[1]), .j(j[1]), .k(k[1]), .busy(busy[1]), .done(done[1]),
    .mismatch(mismatch[1]), .err_cnt(err1));

  jk_seq_driver #(.WIDTH(8), .TOGGLE_MODE(1'b0), .ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[2]), .in_data(in_data),
    .q_fb(q_fb[2]), .j(j[2]), .k(k[2]), .busy(busy[2]), .done(done[2]),
    .mismatch(mismatch[2]), .err_cnt(err2));

  // Behavioural jk_ff per instance
  always @(posedge clk or posedge reset) begin
    if (reset) q <= 3'b000;
    else begin
      for (int i = 0; i < 3; i++) begin
        case ({j[i], k[i]})
          2'b10:   q[i] <= 1'b1;
          2'b01:   q[i] <= 1'b0;
          2'b11:   q[i] <= ~q[i];
          default: q[i] <= q[i];
        endcase
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d);
    int w = 0;
    while (!in_ready[0] && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    n_checks++;
    if (in_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready[0]);
    end
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({j, k} !== 6'b0) begin
      n_fail++; $display("FAIL rst_jk: j=%b k=%b required 000 000", j, k);
    end
    n_checks++;
    if (in_ready !== 3'b111 || busy !== 3'b000 || done !== 3'b000 || mismatch !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_ctl: rdy=%b busy=%b done=%b mm=%b required 111 000 000 000",
               in_ready, busy, done, mismatch);
    end
    n_checks++;
    if (err0 !== 8'd0 || err2 !== 2'd0) begin
      n_fail++; $display("FAIL rst_err: err0=%0d err2=%0d required 0 0", err0, err2);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_pattern();
    bit eb;
    do_reset();
    send_word(8'hA5);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      eb = exp_q.pop_front();
      n_checks++;
      if (q[0] !== eb) begin
        n_fail++; $display("FAIL pat_q[%0d]: q=%b required %b", c - 1, q[0], eb);
      end
      n_checks++;
      if (done[0] !== (c == 8)) begin
        n_fail++; $display("FAIL pat_done cyc %0d: done=%b required %b", c, done[0], (c == 8));
      end
      n_checks++;
      if (mismatch[0] !== 1'b0) begin
        n_fail++; $display("FAIL pat_mm cyc %0d: mismatch=%b required 0", c, mismatch[0]);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready[0] !== 1'b1 || done[0] !== 1'b0 || err0 !== 8'd0) begin
      n_fail++;
      $display("FAIL pat_end: rdy=%b done=%b err=%0d required 1 0 0", in_ready[0], done[0], err0);
    end
  endtask

  task automatic test_toggle();
    bit eb;
    do_reset();
    send_word(8'hFF);
    n_checks++;
    if ({j[1], k[1]} !== 2'b11 || {j[0], k[0]} !== 2'b10) begin
      n_fail++;
      $display("FAIL tog_first: jk1=%b%b jk0=%b%b required 11 10", j[1], k[1], j[0], k[0]);
    end
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      eb = exp_q.pop_front();
      n_checks++;
      if (q[1] !== eb) begin
        n_fail++; $display("FAIL tog_q[%0d]: q=%b required %b", c - 1, q[1], eb);
      end
      n_checks++;
      if ({j[1], k[1]} !== 2'b00) begin
        n_fail++; $display("FAIL tog_hold cyc %0d: jk=%b%b required 00", c, j[1], k[1]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mismatch();
    int p0 = 0;
    int p2 = 0;
    int exp_p;
    logic [7:0] exp_e0;
    logic [1:0] exp_e2;
`ifdef JK_DRV_CHECK_EN
    exp_p = 8; exp_e0 = 8'd8; exp_e2 = 2'd3;
`else
    exp_p = 0; exp_e0 = 8'd0; exp_e2 = 2'd0;
`endif
    do_reset();
    force_low = 1'b1;
    send_word(8'hFF);
    exp_q.delete();
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      n_checks++;
      if ({j[0], k[0]} !== ((c <= 7) ? 2'b10 : 2'b00)) begin
        n_fail++;
        $display("FAIL mm_jk cyc %0d: jk=%b%b required %b", c, j[0], k[0], (c <= 7) ? 2'b10 : 2'b00);
      end
      p0 += int'(mismatch[0]);
      p2 += int'(mismatch[2]);
    end
    n_checks++;
    if (p0 != exp_p || p2 != exp_p) begin
      n_fail++; $display("FAIL mm_pulses: p0=%0d p2=%0d required %0d", p0, p2, exp_p);
    end
    n_checks++;
    if (err0 !== exp_e0) begin
      n_fail++; $display("FAIL mm_err0: err=%0d required %0d", err0, exp_e0);
    end
    n_checks++;
    if (err2 !== exp_e2) begin
      n_fail++; $display("FAIL mm_err2_sat: err=%0d required %0d", err2, exp_e2);
    end
    force_low = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit eb;
    send_word(8'h3C);
    exp_q.delete();
    repeat (3) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL rm_busy: busy=%b required 1", busy[0]);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({j[0], k[0]} !== 2'b00 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_now: jk=%b%b rdy=%b busy=%b required 00 1 0", j[0], k[0], in_ready[0], busy[0]);
    end
    n_checks++;
    if (err0 !== 8'd0) begin
      n_fail++; $display("FAIL rm_err: err=%0d required 0", err0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    send_word(8'h01);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      eb = exp_q.pop_front();
      n_checks++;
      if (q[0] !== eb) begin
        n_fail++; $display("FAIL rm_q[%0d]: q=%b required %b", c - 1, q[0], eb);
      end
    end
    n_checks++;
    if (done[0] !== 1'b1) begin
      n_fail++; $display("FAIL rm_done: done=%b required 1", done[0]);
    end
    @(posedge clk); #1;
    n_checks++;
    if (err0 !== 8'd0 || in_ready[0] !== 1'b1) begin
      n_fail++; $display("FAIL rm_end: err=%0d rdy=%b required 0 1", err0, in_ready[0]);
    end
  endtask

  task automatic test_back_to_back();
    int acc[2];
    int na = 0;
    int lowcnt = 0;
    bit acc_next = 1'b0;
    bit eb;
    exp_q.delete();
    in_valid = 1'b1;
    in_data  = 8'h0F;
    for (int n = 0; n < 23; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      if (exp_q.size() > 0) begin
        eb = exp_q.pop_front();
        n_checks++;
        if (q[0] !== eb) begin
          n_fail++; $display("FAIL b2b_q n=%0d: q=%b required %b", n, q[0], eb);
        end
      end
      if (acc_next) begin
        if (na < 2) acc[na] = n;
        na++;
        for (int i = 0; i < 8; i++) exp_q.push_back(in_data[i]);
        if (na == 1) in_data = 8'hF0;
        else in_valid = 1'b0;
      end
      if (na == 1 && !in_ready[0]) lowcnt++;
      n_checks++;
      if (busy[0] !== ~in_ready[0]) begin
        n_fail++; $display("FAIL b2b_busy n=%0d: busy=%b required %b", n, busy[0], ~in_ready[0]);
      end
      acc_next = in_valid && in_ready[0];
    end
    n_checks++;
    if (na != 2 || acc[1] - acc[0] != 10) begin
      n_fail++; $display("FAIL b2b_gap: accepts=%0d gap=%0d required 2 10", na, acc[1] - acc[0]);
    end
    n_checks++;
    if (lowcnt != 9 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_rdy_low: cycles=%0d left=%0d required 9 0", lowcnt, exp_q.size());
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    force_low = 1'b0;
    test_reset();
    test_pattern();
    test_toggle();
    test_mismatch();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
